cn_axi_read_arbiter: RTL and testbench

//  Shares the single 128-bit AXI4 read master of the cryptonight kernel between N_REQ scratchpad

---
 rtl/cn_axi_read_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cn_axi_read_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cn_axi_read_arbiter.sv
// Round-robin sharing of one in-order AXI4 read master between N_REQ requesters.
// A FIFO of grant indices routes each returning burst back to the requester that issued it.
module cn_axi_read_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned OT_DEPTH = 16,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 128
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [N_REQ*ADDR_W-1:0]     req_araddr,
  input  logic [N_REQ*8-1:0]          req_arlen,
  input  logic [N_REQ-1:0]            req_arvalid,
  output logic [N_REQ-1:0]            req_arready,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [1:0]                  req_rresp,
  output logic                        req_rlast,
  output logic [N_REQ-1:0]            req_rvalid,
  input  logic [N_REQ-1:0]            req_rready,
  output logic [ADDR_W-1:0]           m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [1:0]                  m_axi_arburst,
  output logic [2:0]                  m_axi_arsize,
  output logic [3:0]                  m_axi_arcache,
  output logic                        m_axi_arlock,
  output logic [2:0]                  m_axi_arprot,
  output logic [3:0]                  m_axi_arqos,
  input  logic [DATA_W-1:0]           m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic [$clog2(OT_DEPTH):0]   outstanding
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned AW    = $clog2(OT_DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              ar_vld_q, ar_vld_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [PTR_W-1:0]  mem_q [OT_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  winner;
  logic              found;
  logic              can_load;
  logic              grant;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PTR_W-1:0]  head;
  logic              push;
  logic              pop;

  assign fifo_full  = (cnt_q == CNT_W'(OT_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // Round-robin scan starting at rr_ptr_q, wrapping at N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_arvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A grant also needs a free order-FIFO slot; a pop only frees it next cycle.
  assign can_load = (!ar_vld_q || m_axi_arready) && !fifo_full;
  assign grant    = found && can_load && !ap_rst;
  assign push     = grant;
  assign pop      = !fifo_empty && m_axi_rvalid && m_axi_rready && m_axi_rlast;

  always_comb begin
    req_arready = '0;
    if (grant) begin
      req_arready[winner] = 1'b1;
    end
  end

  // Next state for the RR pointer, AR output register and order FIFO pointers.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    ar_vld_d = ar_vld_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    if (grant) begin
      rr_ptr_d = (32'(winner) == N_REQ - 1) ? '0 : winner + PTR_W'(1);
      ar_vld_d = 1'b1;
      araddr_d = req_araddr[32'(winner)*ADDR_W +: ADDR_W];
      arlen_d  = req_arlen[32'(winner)*8 +: 8];
    end else if (m_axi_arready) begin
      ar_vld_d = 1'b0;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr_q <= '0;
      ar_vld_q <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < OT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ar_vld_q <= ar_vld_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= winner;
      end
    end
  end

  // R routing: only the FIFO head owner sees valid; a beat with no owner is stalled.
  always_comb begin
    m_axi_rready = !fifo_empty && req_rready[head];
    req_rvalid   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_rvalid[i] = !fifo_empty && m_axi_rvalid && (head == PTR_W'(i));
    end
  end

  assign req_rdata = m_axi_rdata;
  assign req_rresp = m_axi_rresp;
  assign req_rlast = m_axi_rlast;

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = ar_vld_q;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arsize  = 3'b100;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign outstanding   = cnt_q;

endmodule

// File: tb/tb_cn_axi_read_arbiter.sv
// Bench for cn_axi_read_arbiter: grant table, AR/R scoreboards and hand-written
// reset, ordering, full-FIFO and arready-stall sequences.
module tb_cn_axi_read_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned OT = 16;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 128;

  logic              ap_clk;
  logic              ap_rst;
  logic [N*AW-1:0]   req_araddr;
  logic [N*8-1:0]    req_arlen;
  logic [N-1:0]      req_arvalid;
  logic [N-1:0]      req_arready;
  logic [DW-1:0]     req_rdata;
  logic [1:0]        req_rresp;
  logic              req_rlast;
  logic [N-1:0]      req_rvalid;
  logic [N-1:0]      req_rready;
  logic [AW-1:0]     m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [1:0]        m_axi_arburst;
  logic [2:0]        m_axi_arsize;
  logic [3:0]        m_axi_arcache;
  logic              m_axi_arlock;
  logic [2:0]        m_axi_arprot;
  logic [3:0]        m_axi_arqos;
  logic [DW-1:0]     m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [4:0]        outstanding;

  cn_axi_read_arbiter #(.N_REQ(N), .OT_DEPTH(OT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arvalid(req_arvalid),
    .req_arready(req_arready), .req_rdata(req_rdata), .req_rresp(req_rresp),
    .req_rlast(req_rlast), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_arburst(m_axi_arburst), .m_axi_arsize(m_axi_arsize),
    .m_axi_arcache(m_axi_arcache), .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot),
    .m_axi_arqos(m_axi_arqos), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .outstanding(outstanding)
  );

  typedef struct {
    int unsigned owner;
    logic [63:0] addr;
    logic [7:0]  len;
  } exp_t;

  typedef struct {
    logic [3:0] arvalid;
    logic       arready;
    logic [3:0] exp_rdy;
  } vec_t;

  exp_t        ar_q[$];
  exp_t        r_q[$];
  exp_t        mon_e;
  vec_t        vt[12];
  logic [63:0] a_tab[4];
  logic [7:0]  l_tab[4];
  logic [DW-1:0] hold_d;
  int unsigned total = 0;
  int unsigned bad   = 0;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int unsigned i);
    return 4'(1) << i;
  endfunction

  task automatic set_req(input int unsigned i, input logic [63:0] ad, input logic [7:0] ln);
    a_tab[i] = ad;
    l_tab[i] = ln;
    req_araddr[i*64 +: 64] = ad;
    req_arlen[i*8 +: 8]    = ln;
  endtask

  task automatic expect_grant(input int unsigned i);
    exp_t e;
    e.owner = i;
    e.addr  = a_tab[i];
    e.len   = l_tab[i];
    ar_q.push_back(e);
    r_q.push_back(e);
  endtask

  // Slave returns the oldest expected burst; every accepted beat is checked.
  task automatic r_burst(input logic [1:0] resp);
    exp_t e;
    int unsigned w;
    logic [DW-1:0] d;
    if (r_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL r_queue_empty: got 0 bursts want 1");
      return;
    end
    e = r_q[0];
    for (int unsigned b = 0; b <= 32'(e.len); b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m_axi_rdata  = d;
      m_axi_rresp  = resp;
      m_axi_rlast  = (b == 32'(e.len));
      m_axi_rvalid = 1'b1;
      w = 0;
      #1;
      while (!m_axi_rready && w < 20) begin
        @(posedge ap_clk);
        #2;
        w++;
      end
      if (!m_axi_rready) begin
        total++;
        bad++;
        $display("FAIL r_timeout: got rready=0 want 1");
        m_axi_rvalid = 1'b0;
        return;
      end
      chk("r_owner", 128'(req_rvalid), 128'(onehot(e.owner)));
      chk("r_data", 128'(req_rdata), 128'(d));
      chk("r_resp_last", 128'({req_rresp, req_rlast}), 128'({resp, (b == 32'(e.len))}));
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    void'(r_q.pop_front());
  endtask

  // AR scoreboard: each handshake must match the oldest expected grant.
  always @(negedge ap_clk) begin
    if (!ap_rst && m_axi_arvalid && m_axi_arready) begin
      if (ar_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ar_unexpected: got addr %0h want none", m_axi_araddr);
      end else begin
        mon_e = ar_q.pop_front();
        chk("ar_addr", 128'(m_axi_araddr), 128'(mon_e.addr));
        chk("ar_len", 128'(m_axi_arlen), 128'(mon_e.len));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{4'hF, 1'b1, 4'h1};
    vt[1]  = '{4'hF, 1'b1, 4'h2};
    vt[2]  = '{4'hF, 1'b1, 4'h4};
    vt[3]  = '{4'hF, 1'b1, 4'h8};
    vt[4]  = '{4'hF, 1'b1, 4'h1};
    vt[5]  = '{4'h4, 1'b1, 4'h4};
    vt[6]  = '{4'h3, 1'b1, 4'h1};
    vt[7]  = '{4'h3, 1'b0, 4'h0};
    vt[8]  = '{4'h3, 1'b1, 4'h2};
    vt[9]  = '{4'h0, 1'b1, 4'h0};
    vt[10] = '{4'h8, 1'b0, 4'h8};
    vt[11] = '{4'h9, 1'b0, 4'h0};

    ap_rst = 1'b1;
    req_araddr = '0; req_arlen = '0; req_arvalid = '0; req_rready = 4'hF;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
    tick(); tick();
    chk("rst_arvalid", 128'(m_axi_arvalid), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_rready", 128'(m_axi_rready), 128'(0));
    chk("rst_rvalid", 128'(req_rvalid), 128'(0));
    chk("rst_araddr_len", 128'({m_axi_araddr, m_axi_arlen}), 128'(0));
    chk("const_fields",
        128'({m_axi_arburst, m_axi_arsize, m_axi_arcache, m_axi_arlock, m_axi_arprot, m_axi_arqos}),
        128'({2'b01, 3'b100, 4'b0011, 1'b0, 3'b000, 4'b0000}));
    ap_rst = 1'b0;
    tick();

    // Single request: AR one cycle later, 4 beats to req0, occupancy back to 0.
    set_req(0, 64'h1000, 8'd3);
    req_arvalid = 4'h1;
    #1 chk("single_grant", 128'(req_arready), 128'(4'h1));
    expect_grant(0);
    tick();
    req_arvalid = 4'h0;
    #1;
    chk("single_arvalid", 128'(m_axi_arvalid), 128'(1));
    chk("single_araddr", 128'(m_axi_araddr), 128'(64'h1000));
    chk("single_arlen", 128'(m_axi_arlen), 128'(3));
    chk("single_outst1", 128'(outstanding), 128'(1));
    m_axi_arready = 1'b1;
    tick();
    r_burst(2'b00);
    chk("single_outst0", 128'(outstanding), 128'(0));

    // Ordering: req2 then req1; second burst also carries SLVERR through.
    set_req(2, 64'h3000, 8'd0);
    set_req(1, 64'h4000, 8'd0);
    req_arvalid = 4'h4;
    #1 chk("ord_grant2", 128'(req_arready), 128'(4'h4));
    expect_grant(2);
    tick();
    req_arvalid = 4'h2;
    #1 chk("ord_grant1", 128'(req_arready), 128'(4'h2));
    expect_grant(1);
    tick();
    req_arvalid = 4'h0;
    tick();
    r_burst(2'b00);
    r_burst(2'b10);

    // Stray beat with empty order FIFO is stalled and routed nowhere.
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    #1;
    chk("stray_rvalid", 128'(req_rvalid), 128'(0));
    chk("stray_rready", 128'(m_axi_rready), 128'(0));
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    chk("stray_outst", 128'(outstanding), 128'(0));

    // Asynchronous reset in the middle of a burst.
    m_axi_arready = 1'b0;
    set_req(0, 64'h5000, 8'd3);
    req_arvalid = 4'h1;
    #1 chk("rst_mid_grant", 128'(req_arready), 128'(4'h1));
    tick();
    m_axi_rvalid = 1'b1;
    #1;
    chk("rst_mid_beat", 128'({m_axi_rready, req_rvalid}), 128'({1'b1, 4'h1}));
    tick();
    #1 ap_rst = 1'b1;
    #1;
    chk("rst_async_arvalid", 128'(m_axi_arvalid), 128'(0));
    chk("rst_async_arready", 128'(req_arready), 128'(0));
    chk("rst_async_rvalid", 128'(req_rvalid), 128'(0));
    chk("rst_async_rready", 128'(m_axi_rready), 128'(0));
    chk("rst_async_outst", 128'(outstanding), 128'(0));
    req_arvalid  = 4'h0;
    m_axi_rvalid = 1'b0;
    ar_q.delete();
    r_q.delete();
    tick();
    ap_rst = 1'b0;
    tick();

    // Grant table: round-robin order, arready stalls, sparse requesters.
    for (int unsigned i = 0; i < 4; i++) set_req(i, 64'h1000_0000 + 64'(i) * 64'h100, 8'(i));
    for (int unsigned i = 0; i < 12; i++) begin
      req_arvalid   = vt[i].arvalid;
      m_axi_arready = vt[i].arready;
      #1 chk($sformatf("tbl_grant%0d", i), 128'(req_arready), 128'(vt[i].exp_rdy));
      for (int unsigned j = 0; j < 4; j++) if (vt[i].exp_rdy[j]) expect_grant(j);
      tick();
    end
    req_arvalid   = 4'h0;
    m_axi_arready = 1'b1;
    chk("tbl_outst", 128'(outstanding), 128'(9));
    tick(); tick();
    while (r_q.size() > 0) r_burst(2'b00);
    chk("tbl_outst0", 128'(outstanding), 128'(0));

    // Fill the order FIFO; the 17th request must wait.
    set_req(0, 64'h2000, 8'd0);
    req_arvalid = 4'h1;
    for (int unsigned k = 0; k < 16; k++) begin
      #1 chk($sformatf("fill_grant%0d", k), 128'(req_arready), 128'(4'h1));
      expect_grant(0);
      tick();
    end
    chk("full_outst", 128'(outstanding), 128'(16));
    for (int unsigned k = 0; k < 3; k++) begin
      #1 chk("full_blocked", 128'(req_arready), 128'(0));
      tick();
    end

    // Requester not ready: master rready low, beat held.
    req_rready   = 4'h0;
    hold_d       = {$urandom, $urandom, $urandom, $urandom};
    m_axi_rdata  = hold_d;
    m_axi_rlast  = 1'b1;
    m_axi_rvalid = 1'b1;
    for (int unsigned k = 0; k < 2; k++) begin
      #1;
      chk("bp_rready", 128'(m_axi_rready), 128'(0));
      chk("bp_rvalid", 128'(req_rvalid), 128'(4'h1));
      chk("bp_rdata", 128'(req_rdata), 128'(hold_d));
      tick();
    end
    chk("bp_outst", 128'(outstanding), 128'(16));

    // Pop at full: slot is only reusable the following cycle.
    m_axi_arready = 1'b0;
    req_rready    = 4'hF;
    #1;
    chk("full_pop_nobypass", 128'(req_arready), 128'(0));
    chk("full_pop_rready", 128'(m_axi_rready), 128'(1));
    tick();
    void'(r_q.pop_front());
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    chk("after_pop_outst", 128'(outstanding), 128'(15));
    #1 chk("refill_grant", 128'(req_arready), 128'(4'h1));
    expect_grant(0);
    tick();
    chk("refill_outst", 128'(outstanding), 128'(16));

    // arready low: AR payload stable, no grants, even if requester inputs change.
    set_req(0, 64'h2F00, 8'd0);
    for (int unsigned k = 0; k < 5; k++) begin
      #1;
      chk("stall_arvalid", 128'(m_axi_arvalid), 128'(1));
      chk("stall_ar", 128'({m_axi_araddr, m_axi_arlen}), 128'({64'h2000, 8'd0}));
      chk("stall_nogrant", 128'(req_arready), 128'(0));
      tick();
    end
    r_burst(2'b00);
    chk("stall_pop_outst", 128'(outstanding), 128'(15));

    // Push and pop in the same cycle leave occupancy unchanged.
    m_axi_arready = 1'b1;
    #1 chk("pp_grant", 128'(req_arready), 128'(4'h1));
    expect_grant(0);
    r_burst(2'b00);
    req_arvalid = 4'h0;
    chk("pp_outst", 128'(outstanding), 128'(15));
    tick(); tick();
    while (r_q.size() > 0) r_burst(2'b00);
    chk("end_outst", 128'(outstanding), 128'(0));
    chk("end_ar_q", 128'(ar_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
